div_iter_ctrl: RTL and testbench

Radix-4 digit-recurrence controller for the mantissa divider, maximally redundant digit set {-3..+3}. It holds the partial remainder and drives one-hot digit-select lines to the divisor-multiple generator (`slct_qd`), which returns q·d in the same cycle. It then updates the remainder and assembles the quotient by on-the-fly conversion. Downstream rounding consumes `quot` and `sticky`.

---
 rtl/div_iter_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_div_iter_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_iter_ctrl.sv
// Radix-4 digit-recurrence divider controller (digits -3..+3, on-the-fly quotient conversion).
// Latency: 16 cycles start-to-done (ITER digits + correction); shorter with DIV_EARLY_TERM_EN on exact remainders.
// Backpressure: start is taken only in IDLE (busy=0); starts while busy are dropped, operands are not resampled.
// Optional build macro: DIV_EARLY_TERM_EN (finish as soon as the partial remainder reaches zero).
module div_iter_ctrl #(
    parameter int ITER = 14
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [26:0] x,
    input  logic [26:0] d,
    output logic [26:0] d_out,
    output logic        mul_n3,
    output logic        mul_n2,
    output logic        mul_n1,
    output logic        mul_0,
    output logic        mul_1,
    output logic        mul_2,
    output logic        mul_3,
    input  logic [26:0] qd,
    output logic        busy,
    output logic        done,
    output logic [26:0] quot,
    output logic        sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_CORR = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ITER - 1);

    state_t      state;
    state_t      state_nxt;

    logic [26:0] w;          // partial remainder, two's complement
    logic [26:0] q_acc;      // on-the-fly quotient Q
    logic [26:0] qm_acc;     // on-the-fly quotient QM = Q - 1 ulp
    logic [3:0]  cnt;
    logic        first;

    logic [26:0] y;
    logic        y_neg;
    logic [26:0] y_abs;
    logic [26:0] d2;
    logic [26:0] d3;
    logic [1:0]  mag;
    logic [2:0]  q_dig;      // signed digit, two's complement
    logic        q_pos;
    logic        q_neg;
    logic [26:0] w_nxt;
    logic [26:0] q_src;
    logic [26:0] qm_src;
    logic [26:0] q_next;
    logic [26:0] qm_next;
    logic [1:0]  qm_low;
    logic [26:0] q_upd;
    logic        early;
    logic [6:0]  sel;        // {n3, n2, n1, 0, 1, 2, 3}

    // Digit selection from the shifted remainder, remainder update and quotient conversion.
    always_comb begin
        y      = first ? w : (w << 2);
        y_neg  = y[26];
        y_abs  = y_neg ? (27'd0 - y) : y;
        d2     = d_out << 1;
        d3     = d_out + d2;

        if (y_abs >= d3) begin
            mag = 2'd3;
        end else if (y_abs >= d2) begin
            mag = 2'd2;
        end else if (y_abs >= d_out) begin
            mag = 2'd1;
        end else begin
            mag = 2'd0;
        end

        q_dig  = y_neg ? (3'd0 - {1'b0, mag}) : {1'b0, mag};
        q_pos  = !y_neg && (mag != 2'd0);
        q_neg  = y_neg && (mag != 2'd0);

        w_nxt  = y - qd;

        // The low two bits of a negative digit already equal 4+q, and (q-1) mod 4
        // gives both q-1 for q>0 and 3+q for q<=0, so only the source register differs.
        q_src   = q_neg ? qm_acc : q_acc;
        qm_src  = q_pos ? q_acc : qm_acc;
        qm_low  = q_dig[1:0] - 2'd1;
        q_next  = (q_src << 2) | {25'd0, q_dig[1:0]};
        qm_next = (qm_src << 2) | {25'd0, qm_low};
    end

`ifdef DIV_EARLY_TERM_EN
    logic [3:0]  rem_dig;
    logic [4:0]  et_sh;

    // Exact remainder before the last digit: pad the quotient with the remaining zero digits.
    always_comb begin
        rem_dig = LAST_CNT - cnt;
        et_sh   = {rem_dig, 1'b0};
        early   = (w_nxt == 27'd0) && (cnt != LAST_CNT);
        q_upd   = early ? (q_next << et_sh) : q_next;
    end
`else
    // Fixed-length recurrence: the quotient always takes the converted value.
    always_comb begin
        early = 1'b0;
        q_upd = q_next;
    end
`endif

    // Next-state decode and one-hot multiple select (mul_0 outside the iteration state).
    always_comb begin
        state_nxt = state;
        sel       = 7'b0001000;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_ITER;
                end
            end
            S_ITER: begin
                case (q_dig)
                    3'b101:  sel = 7'b1000000;
                    3'b110:  sel = 7'b0100000;
                    3'b111:  sel = 7'b0010000;
                    3'b001:  sel = 7'b0000100;
                    3'b010:  sel = 7'b0000010;
                    3'b011:  sel = 7'b0000001;
                    default: sel = 7'b0001000;
                endcase
                if ((cnt == LAST_CNT) || early) begin
                    state_nxt = S_CORR;
                end
            end
            S_CORR: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign {mul_n3, mul_n2, mul_n1, mul_0, mul_1, mul_2, mul_3} = sel;
    assign busy = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: operand capture, one digit per cycle, final sign correction of the remainder.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            w      <= 27'd0;
            q_acc  <= 27'd0;
            qm_acc <= '1;
            cnt    <= 4'd0;
            first  <= 1'b0;
            d_out  <= 27'd0;
            quot   <= 27'd0;
            sticky <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        w      <= x;
                        d_out  <= d;
                        q_acc  <= 27'd0;
                        qm_acc <= '1;
                        cnt    <= 4'd0;
                        first  <= 1'b1;
                    end
                end
                S_ITER: begin
                    w      <= w_nxt;
                    q_acc  <= q_upd;
                    qm_acc <= qm_next;
                    first  <= 1'b0;
                    cnt    <= cnt + 4'd1;
                end
                S_CORR: begin
                    // A negative final remainder means Q overshot by one ulp; QM holds Q-1.
                    if (w[26]) begin
                        quot   <= qm_acc;
                        sticky <= 1'b1;
                    end else begin
                        quot   <= q_acc;
                        sticky <= (w != 27'd0);
                    end
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter_ctrl.sv
module tb_div_iter_ctrl;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [26:0] x;
    logic [26:0] d;
    logic [26:0] d_out;
    logic        mul_n3, mul_n2, mul_n1, mul_0, mul_1, mul_2, mul_3;
    logic [26:0] qd;
    logic        busy;
    logic        done;
    logic [26:0] quot;
    logic        sticky;

    logic [6:0]  sel_v;
    int          qsel;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference quantities for the division in flight.
    int     m_dig [14];
    int     m_ndig;
    longint m_quot;
    longint m_sticky;

    always #5 clk = ~clk;

    div_iter_ctrl #(.ITER(14)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .start  (start),
        .x      (x),
        .d      (d),
        .d_out  (d_out),
        .mul_n3 (mul_n3),
        .mul_n2 (mul_n2),
        .mul_n1 (mul_n1),
        .mul_0  (mul_0),
        .mul_1  (mul_1),
        .mul_2  (mul_2),
        .mul_3  (mul_3),
        .qd     (qd),
        .busy   (busy),
        .done   (done),
        .quot   (quot),
        .sticky (sticky)
    );

    assign sel_v = {mul_n3, mul_n2, mul_n1, mul_0, mul_1, mul_2, mul_3};

    // Divisor-multiple generator: q*d_out returned in the same cycle.
    always_comb begin
        qsel = 0;
        if (mul_3)       qsel = 3;
        else if (mul_2)  qsel = 2;
        else if (mul_1)  qsel = 1;
        else if (mul_n1) qsel = -1;
        else if (mul_n2) qsel = -2;
        else if (mul_n3) qsel = -3;
        qd = 27'(qsel * int'(d_out));
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [26:0] rnd_op();
        logic [31:0] r;
        r = $urandom;
        return {4'b0001, r[22:0]};
    endfunction

    // Digit sequence from the selection rule in plain integer arithmetic;
    // quotient and sticky from exact long division.
    task automatic model(input longint xv, input longint dv);
        longint w, y, a, m, q, num;
        w      = xv;
        m_ndig = 14;
        for (int i = 0; i < 14; i++) begin
            y = (i == 0) ? w : 4 * w;
            a = (y < 0) ? -y : y;
            m = a / dv;
            if (m > 3) m = 3;
            q = (y < 0) ? -m : m;
            w = y - q * dv;
            m_dig[i] = int'(q);
`ifdef DIV_EARLY_TERM_EN
            if (w == 0 && m_ndig == 14 && i < 13) m_ndig = i + 1;
`endif
        end
        num      = xv <<< 26;
        m_quot   = num / dv;
        m_sticky = ((num % dv) != 0) ? 1 : 0;
    endtask

    // Launch (unless already launched) and follow one division to done.
    task automatic run_div(input string tag, input logic [26:0] xv, input logic [26:0] dv,
                           input int ign_at, input bit launched, input bit chain,
                           input logic [26:0] nx, input logic [26:0] nd);
        bit seen;
        model(longint'(xv), longint'(dv));
        if (!launched) begin
            @(negedge clk);
            x     = xv;
            d     = dv;
            start = 1'b1;
        end
        seen = 1'b0;
        for (int e = 1; e <= 40 && !seen; e++) begin
            @(negedge clk);
            if (e == 1) begin
                start = 1'b0;
                chk({tag, "/busy"}, busy, 1);
                chk({tag, "/d_out"}, d_out, longint'(dv));
                chk({tag, "/done_low"}, done, 0);
            end
            if (ign_at != 0 && e == ign_at) begin
                x     = rnd_op();
                d     = rnd_op();
                start = 1'b1;
            end
            if (ign_at != 0 && e == ign_at + 1) start = 1'b0;
            chk({tag, "/onehot"}, $onehot(sel_v), 1);
            if (e <= m_ndig) begin
                chk({tag, "/digit"}, qsel, m_dig[e-1]);
            end else if (!done) begin
                chk({tag, "/corr_sel"}, sel_v, 7'b0001000);
            end
            if (done) begin
                seen = 1'b1;
                chk({tag, "/latency"}, e, m_ndig + 2);
                chk({tag, "/quot"}, quot, m_quot);
                chk({tag, "/sticky"}, sticky, m_sticky);
                chk({tag, "/busy_done"}, busy, 0);
                chk({tag, "/d_out_hold"}, d_out, longint'(dv));
                if (chain) begin
                    x     = nx;
                    d     = nd;
                    start = 1'b1;
                end
            end
        end
        chk({tag, "/timeout"}, seen, 1);
        if (!chain) begin
            @(negedge clk);
            chk({tag, "/done_pulse"}, done, 0);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        x     = 27'd0;
        d     = 27'd0;
        #2;
        chk("rst/busy",   busy, 0);
        chk("rst/done",   done, 0);
        chk("rst/quot",   quot, 0);
        chk("rst/sticky", sticky, 0);
        chk("rst/d_out",  d_out, 0);
        chk("rst/sel",    sel_v, 7'b0001000);
        @(negedge clk);
        n_rst = 1'b1;

        // Directed operands, including a back-to-back start in the done cycle.
        run_div("one",    27'h0800000, 27'h0800000, 0, 0, 0, 27'd0, 27'd0);
        chk("one/const", quot, 27'h4000000);
        run_div("x15",    27'h0C00000, 27'h0800000, 0, 0, 0, 27'd0, 27'd0);
        chk("x15/const", quot, 27'h6000000);
        run_div("d15",    27'h0800000, 27'h0C00000, 0, 0, 1, 27'h0FFFFFF, 27'h0800000);
        chk("d15/const", quot, 27'h2AAAAAA);
        run_div("max",    27'h0FFFFFF, 27'h0800000, 0, 1, 0, 27'd0, 27'd0);
        chk("max/const", quot, 27'h7FFFFF8);

        // New start while busy is dropped.
        run_div("ignore", 27'h0800000, 27'h0C00000, 5, 0, 0, 27'd0, 27'd0);

        // Asynchronous reset in the middle of the recurrence.
        @(negedge clk);
        x     = 27'h0C00000;
        d     = 27'h0900000;
        start = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            if (e == 1) start = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        chk("abort/busy",   busy, 0);
        chk("abort/done",   done, 0);
        chk("abort/quot",   quot, 0);
        chk("abort/sticky", sticky, 0);
        chk("abort/d_out",  d_out, 0);
        chk("abort/sel",    sel_v, 7'b0001000);
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            chk("abort/no_done", done, 0);
        end
        n_rst = 1'b1;
        run_div("after", 27'h0C00000, 27'h0900000, 0, 0, 0, 27'd0, 27'd0);

        // Random operands in the normalised range.
        for (int k = 0; k < 20; k++) begin
            run_div("rand", rnd_op(), rnd_op(), 0, 0, 0, 27'd0, 27'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
